// File: rtl/pipe_in_test_seq.sv
// pipe_in_test_seq: run controller for the Pipe In checker datapath.
// Latches a host test configuration, holds the checker in reset while arming,
// counts accepted writes until the programmed count or an idle timeout, then
// lets the checker's error count settle and reports pass/fail and run status.
module pipe_in_test_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             thr_update,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [31:0]      cfg_throttle,
  input  logic [2:0]       cfg_pattern,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             pipe_in_write,
  input  logic [31:0]      chk_error_count,
  output logic             chk_reset,
  output logic             chk_throttle_set,
  output logic [31:0]      chk_throttle_val,
  output logic [2:0]       chk_pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic             overrun,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      err_latched
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             ph_q, ph_d;          // second-cycle marker for ARM and DRAIN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [31:0]      thr_q, thr_d;
  logic [31:0]      err_q, err_d;
  logic [2:0]       pat_q, pat_d;
  logic             thr_set_q, thr_set_d;
  logic             chk_rst_q, chk_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timed_q, timed_d;
  logic             over_q, over_d;
  logic             launch;
  logic [CNT_W-1:0] word_inc, idle_inc;

  assign launch   = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign word_inc = word_q + ONE;
  assign idle_inc = idle_q + ONE;

  // Next-state, counter and registered-output logic for the whole run.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    word_d    = word_q;
    cyc_d     = cyc_q;
    idle_d    = idle_q;
    thr_d     = thr_q;
    err_d     = err_q;
    pat_d     = pat_q;
    thr_set_d = 1'b0;
    timed_d   = timed_q;
    over_d    = over_q;

    case (state_q)
      S_IDLE: ;
      S_ARM: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          // A zero-length run has nothing to count and goes straight to drain.
          state_d = (cnt_q == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + ONE;
        if (thr_update) begin
          thr_d     = cfg_throttle;
          thr_set_d = 1'b1;
        end
        if (pipe_in_write) begin
          word_d = word_inc;
          idle_d = '0;
          if (word_inc == cnt_q) begin
            state_d = S_DRAIN;
            ph_d    = 1'b0;
          end
        end else begin
          idle_d = idle_inc;
          // Timeout only fires on a write-free cycle, so a terminal write wins.
          if ((tmo_q != '0) && (idle_inc == tmo_q)) begin
            timed_d = 1'b1;
            state_d = S_DRAIN;
            ph_d    = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (pipe_in_write) over_d = 1'b1;
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          err_d   = chk_error_count;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (pipe_in_write) over_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      cnt_d   = cfg_count;
      tmo_d   = cfg_timeout;
      thr_d   = cfg_throttle;
      pat_d   = cfg_pattern;
      word_d  = '0;
      cyc_d   = '0;
      idle_d  = '0;
      err_d   = '0;
      timed_d = 1'b0;
      over_d  = 1'b0;
      ph_d    = 1'b0;
      state_d = S_ARM;
    end

    // Abort beats everything, including a coincident start; counters are kept.
    if (abort) begin
      state_d   = S_IDLE;
      ph_d      = 1'b0;
      timed_d   = 1'b0;
      over_d    = 1'b0;
      thr_set_d = 1'b0;
    end

    busy_d    = (state_d == S_ARM) | (state_d == S_RUN) | (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    chk_rst_d = (state_d == S_IDLE) | (state_d == S_ARM);
    pass_d    = done_d & (err_d == 32'd0) & ~timed_d & ~over_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ph_q      <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      word_q    <= '0;
      cyc_q     <= '0;
      idle_q    <= '0;
      thr_q     <= '0;
      err_q     <= '0;
      pat_q     <= '0;
      thr_set_q <= 1'b0;
      chk_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timed_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      word_q    <= word_d;
      cyc_q     <= cyc_d;
      idle_q    <= idle_d;
      thr_q     <= thr_d;
      err_q     <= err_d;
      pat_q     <= pat_d;
      thr_set_q <= thr_set_d;
      chk_rst_q <= chk_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timed_q   <= timed_d;
      over_q    <= over_d;
    end
  end

  assign chk_reset        = chk_rst_q;
  assign chk_throttle_set = thr_set_q;
  assign chk_throttle_val = thr_q;
  assign chk_pattern      = pat_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign timed_out        = timed_q;
  assign overrun          = over_q;
  assign word_count       = word_q;
  assign cycle_count      = cyc_q;
  assign err_latched      = err_q;

endmodule

// File: tb/tb_pipe_in_test_seq.sv
// Bench for pipe_in_test_seq: directed scenarios with randomized write gaps,
// expectations computed from the run rules by a gap-based reference model.
module tb_pipe_in_test_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        thr_update = 1'b0;
  logic [31:0] cfg_count = '0;
  logic [31:0] cfg_throttle = '0;
  logic [2:0]  cfg_pattern = '0;
  logic [31:0] cfg_timeout = '0;
  logic        pipe_in_write = 1'b0;
  logic [31:0] chk_error_count = '0;
  logic        chk_reset, chk_throttle_set, busy, done, pass, timed_out, overrun;
  logic [31:0] chk_throttle_val, word_count, cycle_count, err_latched;
  logic [2:0]  chk_pattern;

  int total = 0;
  int bad = 0;

  pipe_in_test_seq #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .thr_update(thr_update), .cfg_count(cfg_count), .cfg_throttle(cfg_throttle),
    .cfg_pattern(cfg_pattern), .cfg_timeout(cfg_timeout),
    .pipe_in_write(pipe_in_write), .chk_error_count(chk_error_count),
    .chk_reset(chk_reset), .chk_throttle_set(chk_throttle_set),
    .chk_throttle_val(chk_throttle_val), .chk_pattern(chk_pattern),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .overrun(overrun), .word_count(word_count), .cycle_count(cycle_count),
    .err_latched(err_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_chk_reset"}, 32'(chk_reset), 32'd1);
    chk({tag, "_thr_set"}, 32'(chk_throttle_set), 32'd0);
    chk({tag, "_thr_val"}, chk_throttle_val, 32'd0);
    chk({tag, "_pattern"}, 32'(chk_pattern), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_timed"}, 32'(timed_out), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_words"}, word_count, 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
    chk({tag, "_err"}, err_latched, 32'd0);
  endtask

  // Launch a run, then three edges later the block is in RUN.
  task automatic launch(input string tag, input int cnt, input int tmo);
    logic [2:0]  pat;
    logic [31:0] thr;
    pat = 3'($urandom_range(7, 0));
    thr = $urandom;
    cfg_count = cnt; cfg_timeout = tmo; cfg_pattern = pat; cfg_throttle = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_count = $urandom; cfg_pattern = ~pat; cfg_throttle = ~thr;
    chk({tag, "_arm_busy"}, 32'(busy), 32'd1);
    chk({tag, "_arm_rst"}, 32'(chk_reset), 32'd1);
    chk({tag, "_arm_pat"}, 32'(chk_pattern), 32'(pat));
    chk({tag, "_arm_thr"}, chk_throttle_val, thr);
    chk({tag, "_arm_words"}, word_count, 32'd0);
    tick();
    chk({tag, "_arm2_rst"}, 32'(chk_reset), 32'd1);
    tick();
  endtask

  // One run: nw writes separated by random gaps of 0..gapmax idle cycles,
  // optional extra write ov_off cycles after the terminal cycle, optional
  // throttle update in RUN cycle thr_at.
  task automatic run_seq(input string tag, input int cnt, input int tmo, input int nw,
                         input int gapmax, input int ov_off, input logic [31:0] errv,
                         input int thr_at);
    int gaps[$];
    int wpos[$];
    int pos, endc, last, wi;
    bit tmo_end, is_w, exp_ov;
    pos = -1; endc = -1; tmo_end = 0;
    for (int i = 0; i < nw; i++)
      gaps.push_back((gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0)));
    // Reference: a gap of tmo or more idle cycles ends the run tmo cycles
    // after the previous write; otherwise the cnt-th write ends it.
    for (int i = 0; i < nw; i++) begin
      if (tmo != 0 && gaps[i] >= tmo) begin
        endc = pos + tmo; tmo_end = 1; break;
      end
      pos = pos + gaps[i] + 1;
      wpos.push_back(pos);
      if (i + 1 == cnt) begin endc = pos; break; end
    end
    if (endc < 0) begin endc = pos + tmo; tmo_end = 1; end
    exp_ov = (ov_off > 0);

    launch(tag, cnt, tmo);
    chk({tag, "_run_rst"}, 32'(chk_reset), 32'd0);
    chk_error_count = errv;
    last = endc + 2;
    if (ov_off > 0 && endc + ov_off > last) last = endc + ov_off;
    last++;
    wi = 0;
    for (int r = 0; r <= last; r++) begin
      is_w = (wi < wpos.size()) && (wpos[wi] == r);
      if (is_w) wi++;
      pipe_in_write = is_w || (exp_ov && r == endc + ov_off);
      thr_update = (r == thr_at);
      if (r == thr_at) cfg_throttle = 32'hAAAAAAAA;
      tick();
      pipe_in_write = 1'b0;
      thr_update = 1'b0;
      if (thr_at >= 0 && r <= thr_at + 1) begin
        chk({tag, "_thr_set"}, 32'(chk_throttle_set), 32'(r == thr_at));
        if (r == thr_at) chk({tag, "_thr_val"}, chk_throttle_val, 32'hAAAAAAAA);
      end
      if (r == endc + 1) begin
        chk({tag, "_drain_busy"}, 32'(busy), 32'd1);
        chk({tag, "_drain_done"}, 32'(done), 32'd0);
      end
      if (r == endc + 2) begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_words"}, word_count, 32'(wpos.size()));
        chk({tag, "_cycles"}, cycle_count, 32'(endc + 1));
        chk({tag, "_err"}, err_latched, errv);
        chk({tag, "_timed"}, 32'(timed_out), 32'(tmo_end));
        chk({tag, "_done_rst"}, 32'(chk_reset), 32'd0);
      end
    end
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ov));
    chk({tag, "_pass"}, 32'(pass), 32'((errv == 0) && !tmo_end && !exp_ov));
    chk({tag, "_words_end"}, word_count, 32'(wpos.size()));
  endtask

  initial begin
    reset_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();
    chk("idle_rst", 32'(chk_reset), 32'd1);

    run_seq("basic16", 16, 0, 16, 0, 0, 32'd0, -1);
    run_seq("err8", 8, 0, 8, 3, 0, 32'd2, -1);
    run_seq("timeout", 100, 50, 40, 3, 0, 32'd0, -1);
    run_seq("ovr_drain", 4, 0, 4, 0, 1, 32'd0, -1);
    run_seq("ovr_done", 6, 0, 6, 2, 5, 32'd0, -1);
    run_seq("throttle", 10, 0, 10, 1, 0, 32'd0, 3);
    for (int k = 0; k < 4; k++)
      run_seq("random", 20, 8, 20, 12, 0, 32'($urandom_range(3, 0)), 2);

    // Abort at RUN cycle 10 after ten back-to-back writes.
    launch("abort", 100, 0);
    for (int r = 0; r < 10; r++) begin
      pipe_in_write = 1'b1;
      tick();
    end
    pipe_in_write = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rst", 32'(chk_reset), 32'd1);
    chk("abort_words", word_count, 32'd10);

    // Start and abort together: abort wins.
    cfg_count = 5;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(busy), 32'd0);
    chk("startabort_rst", 32'(chk_reset), 32'd1);

    // Zero-length run; a second start while busy must not re-latch.
    cfg_count = 0; cfg_timeout = 0; chk_error_count = 0;
    start = 1'b1;
    tick();
    cfg_count = 7;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("zero_busy4", 32'(busy), 32'd1);
    chk("zero_done4", 32'(done), 32'd0);
    tick();
    chk("zero_done5", 32'(done), 32'd1);
    chk("zero_pass", 32'(pass), 32'd1);
    chk("zero_words", word_count, 32'd0);
    chk("zero_cycles", cycle_count, 32'd0);

    // Reset in the middle of a run, right after a throttle strobe.
    launch("midreset", 50, 0);
    for (int r = 0; r < 5; r++) begin
      pipe_in_write = 1'b1;
      thr_update = (r == 4);
      tick();
    end
    pipe_in_write = 1'b0;
    thr_update = 1'b0;
    chk("midreset_words", word_count, 32'd5);
    chk("midreset_thr_set", 32'(chk_throttle_set), 32'd1);
    reset_n = 1'b0;
    tick();
    chk_reset_vals("midreset");
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
